// File: rtl/arbitro_memoria.sv
// Two-port arbiter/sequencer for the single-port data memory.
// Port A (core) has priority; a streak limit keeps port B (debug scanner) from starving.
module arbitro_memoria #(
    parameter int unsigned AW           = 5,
    parameter int unsigned DW           = 32,
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned MAX_A_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned CW = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam int unsigned SW = (MAX_A_STREAK < 1) ? 1 : $clog2(MAX_A_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] lat_cnt;
    logic [SW-1:0] streak;
    logic          owner_b;
    logic          op_we;
    logic          pick_b_c;

    // B wins when alone, or when A has used up its streak while B waits
    assign pick_b_c = b_req && (!a_req || (streak == SW'(MAX_A_STREAK)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            streak    <= '0;
            owner_b   <= 1'b0;
            op_we     <= 1'b0;
            a_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_gnt     <= 1'b0;
            b_rvalid  <= 1'b0;
            b_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        owner_b   <= pick_b_c;
                        op_we     <= pick_b_c ? b_we : a_we;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_b_c ? b_we : a_we;
                        mem_addr  <= pick_b_c ? b_addr : a_addr;
                        mem_wdata <= pick_b_c ? b_wdata : a_wdata;
                        a_gnt     <= !pick_b_c;
                        b_gnt     <= pick_b_c;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                    // Streak only grows while B is actually being held off
                    if (!b_req || pick_b_c) begin
                        streak <= '0;
                    end else if (a_req && (streak != SW'(MAX_A_STREAK))) begin
                        streak <= streak + SW'(1);
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    lat_cnt   <= CW'(1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt >= CW'(READ_LAT)) begin
                        if (owner_b) begin
                            b_rvalid <= 1'b1;
                            if (!op_we) b_rdata <= mem_rdata;
                        end else begin
                            a_rvalid <= 1'b1;
                            if (!op_we) a_rdata <= mem_rdata;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria with a READ_LAT=1 memory model.
module tb_arbitro_memoria;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;
    logic        mem_init;

    logic [31:0] mem [0:31];

    int checks = 0;
    int passed = 0;

    arbitro_memoria #(.AW(5), .DW(32), .READ_LAT(1), .MAX_A_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            2:       init_word = 32'h0000_0B0B;
            3:       init_word = 32'h0000_00AA;
            default: init_word = 32'(i);
        endcase
    endfunction

    // Memory model: registered read data, one cycle after the sampled strobe
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    logic       seen;
    logic [9:0] order;
    int         n;

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        tick(); tick();
        rst = 1'b0; mem_init = 1'b0;

        // 1: idle after reset
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | mem_en | a_gnt | b_gnt | a_rvalid | b_rvalid | busy;
        end
        check("idle_activity", 32'(seen), 32'd0);
        check("idle_a_rdata", a_rdata, 32'd0);
        check("idle_b_rdata", b_rdata, 32'd0);

        // 2: A reads addr 3
        a_req = 1; a_we = 0; a_addr = 5'd3;
        tick();
        check("t2_a_gnt", 32'(a_gnt), 32'd1);
        check("t2_mem_en", 32'(mem_en), 32'd1);
        check("t2_mem_addr", 32'(mem_addr), 32'd3);
        check("t2_busy", 32'(busy), 32'd1);
        a_req = 0;
        tick();
        check("t2_issue_done", 32'({a_gnt, mem_en, a_rvalid}), 32'd0);
        tick();
        check("t2_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t2_a_rdata", a_rdata, 32'h0000_00AA);
        check("t2_b_quiet", 32'({b_gnt, b_rvalid}) | b_rdata, 32'd0);
        tick();
        check("t2_rvalid_pulse", 32'({a_rvalid, busy}), 32'd0);

        // 3: simultaneous requests, A first then B three cycles later
        a_req = 1; a_we = 0; a_addr = 5'd3;
        b_req = 1; b_we = 0; b_addr = 5'd2;
        tick();
        check("t3_first_gnt", 32'({a_gnt, b_gnt}), 32'b10);
        check("t3_first_addr", 32'(mem_addr), 32'd3);
        a_req = 0;
        tick(); tick();
        check("t3_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t3_no_gnt_on_rvalid", 32'({a_gnt, b_gnt}), 32'd0);
        tick();
        check("t3_second_gnt", 32'({a_gnt, b_gnt}), 32'b01);
        check("t3_second_addr", 32'(mem_addr), 32'd2);
        b_req = 0;
        tick(); tick();
        check("t3_b_rvalid", 32'(b_rvalid), 32'd1);
        check("t3_b_rdata", b_rdata, 32'h0000_0B0B);
        tick();

        // 4: both continuous, streak limit -> A,A,A,A,B,A,A,A,A,B
        a_req = 1; a_addr = 5'd1; b_req = 1; b_addr = 5'd2;
        order = '0; n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_gnt || b_gnt) begin
                if (n < 10) order[n] = b_gnt;
                n++;
            end
        end
        a_req = 0; b_req = 0;
        check("t4_grant_count", 32'(n), 32'd10);
        check("t4_grant_order", 32'(order), 32'h0000_0210);
        check("t4_a_rdata", a_rdata, 32'd1);
        tick(); tick();

        // 5: B writes addr 7, then A reads it back
        b_req = 1; b_we = 1; b_addr = 5'd7; b_wdata = 32'h1234_5678;
        tick();
        check("t5_b_gnt", 32'(b_gnt), 32'd1);
        check("t5_mem_we", 32'(mem_we), 32'd1);
        check("t5_mem_wdata", mem_wdata, 32'h1234_5678);
        b_req = 0; b_we = 0; b_wdata = '0;
        tick(); tick();
        check("t5_b_rvalid", 32'(b_rvalid), 32'd1);
        check("t5_b_rdata_kept", b_rdata, 32'h0000_0B0B);
        check("t5_mem7", mem[7], 32'h1234_5678);
        tick();
        a_req = 1; a_we = 0; a_addr = 5'd7;
        tick();
        check("t5_a_gnt", 32'(a_gnt), 32'd1);
        a_req = 0;
        tick(); tick();
        check("t5_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t5_a_rdata", a_rdata, 32'h1234_5678);
        tick();

        // 6: reset during WAIT drops the access
        a_req = 1; a_we = 0; a_addr = 5'd3;
        tick();
        check("t6_a_gnt", 32'(a_gnt), 32'd1);
        a_req = 0;
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 32'({busy, mem_en, a_gnt, a_rvalid}), 32'd0);
        check("t6_rst_a_rdata", a_rdata, 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | a_rvalid;
        end
        check("t6_no_a_rvalid", 32'(seen), 32'd0);
        b_req = 1; b_we = 0; b_addr = 5'd3;
        tick();
        check("t6_b_gnt", 32'(b_gnt), 32'd1);
        b_req = 0;
        tick(); tick();
        check("t6_b_rvalid", 32'(b_rvalid), 32'd1);
        check("t6_b_rdata", b_rdata, 32'h0000_00AA);
        tick();
        check("t6_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
